// File: rtl/cpu_sequencer_if.sv
// Control bundle between the CPU sequencer and its environment (datapath, memory, run control).
// The master side drives run/decode/memory status; the slave side is the sequencer itself.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [2:0]       instr_class;
    logic             branch_taken;
    logic             mem_ready;
    logic             pc_en;
    logic             pc_ld;
    logic             ir_ld;
    logic             mem_rd;
    logic             mem_wr;
    logic             rf_we;
    logic [2:0]       state;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        output run, instr_class, branch_taken, mem_ready,
        input  pc_en, pc_ld, ir_ld, mem_rd, mem_wr, rf_we, state, halted, fault, retired
    );

    modport slave (
        input  run, instr_class, branch_taken, mem_ready,
        output pc_en, pc_ld, ir_ld, mem_rd, mem_wr, rf_we, state, halted, fault, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with memory-wait timeout
// and a retired-instruction counter.
module cpu_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    cpu_sequencer_if.slave bus
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_JUMP   = 3'd4;
    localparam logic [2:0] C_HALT   = 3'd5;

    logic [2:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              fault_reg, fault_next;
    logic              halted_reg;
    logic [CNT_W-1:0]  retired_reg;

    logic              is_mem_class;
    logic              req_active;
    logic              timeout;
    logic              pc_en_c, pc_ld_c, ir_ld_c, mem_rd_c, mem_wr_c, rf_we_c;
    logic [5:0]        strobe_raw, strobe_out;

    // A request is "enabled" while the sequencer is actually asking memory for something.
    // Timeout fires on the TIMEOUT-th consecutive not-ready cycle of that request.
    assign is_mem_class = (bus.instr_class == C_LOAD) || (bus.instr_class == C_STORE);
    assign req_active   = ((state_reg == S_FETCH) && bus.run) || ((state_reg == S_MEM) && is_mem_class);
    assign timeout      = req_active && !bus.mem_ready && (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            fault_reg    <= 1'b0;
            halted_reg   <= 1'b0;
            retired_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            fault_reg    <= fault_next;
            halted_reg   <= (state_next == S_HALT);
            retired_reg  <= retired_reg + CNT_W'(pc_en_c | pc_ld_c);
        end
    end

    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        if (timeout) begin
            state_next = S_HALT;
            fault_next = 1'b1;
        end else begin
            case (state_reg)
                S_FETCH:  if (bus.run && bus.mem_ready) state_next = S_DECODE;
                S_DECODE: begin
                    if (is_mem_class)                  state_next = S_MEM;
                    else if (bus.instr_class == C_HALT) state_next = S_HALT;
                    else                               state_next = S_EXEC;
                end
                S_EXEC:   state_next = S_FETCH;
                S_MEM: begin
                    if (!is_mem_class)                     state_next = S_FETCH;
                    else if (bus.mem_ready)
                        state_next = (bus.instr_class == C_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:     state_next = S_FETCH;
                S_HALT:   state_next = S_HALT;
                default: begin
                    state_next = S_HALT;
                    fault_next = 1'b1;
                end
            endcase
        end

        // The wait counter only ever counts a live, unanswered request.
        wait_cnt_next = '0;
        if (!timeout && req_active && !bus.mem_ready &&
            !((state_next != state_reg) && (state_next == S_FETCH || state_next == S_MEM)))
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end

    always_comb begin
        pc_en_c  = 1'b0;
        pc_ld_c  = 1'b0;
        ir_ld_c  = 1'b0;
        mem_rd_c = 1'b0;
        mem_wr_c = 1'b0;
        rf_we_c  = 1'b0;
        if (!timeout) begin
            case (state_reg)
                S_FETCH: begin
                    mem_rd_c = bus.run;
                    ir_ld_c  = bus.run && bus.mem_ready;
                end
                S_EXEC: begin
                    case (bus.instr_class)
                        C_ALU:    begin rf_we_c = 1'b1; pc_en_c = 1'b1; end
                        C_BRANCH: begin pc_ld_c = bus.branch_taken; pc_en_c = !bus.branch_taken; end
                        C_JUMP:   pc_ld_c = 1'b1;
                        default:  pc_en_c = 1'b1;
                    endcase
                end
                S_MEM: begin
                    mem_rd_c = (bus.instr_class == C_LOAD);
                    mem_wr_c = (bus.instr_class == C_STORE);
                    pc_en_c  = (bus.instr_class == C_STORE) && bus.mem_ready;
                end
                S_WB: begin
                    rf_we_c = 1'b1;
                    pc_en_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset overrides every strobe combinationally, not just at the next edge.
    assign strobe_raw = {pc_en_c, pc_ld_c, ir_ld_c, mem_rd_c, mem_wr_c, rf_we_c};
    for (genvar gi = 0; gi < 6; gi++) begin : g_strobe_gate
        assign strobe_out[gi] = strobe_raw[gi] & ~rst;
    end

    assign bus.pc_en   = strobe_out[5];
    assign bus.pc_ld   = strobe_out[4];
    assign bus.ir_ld   = strobe_out[3];
    assign bus.mem_rd  = strobe_out[2];
    assign bus.mem_wr  = strobe_out[1];
    assign bus.rf_we   = strobe_out[0];
    assign bus.state   = state_reg;
    assign bus.halted  = halted_reg & ~rst;
    assign bus.fault   = fault_reg;
    assign bus.retired = retired_reg;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: a default instance plus a CNT_W=4 instance in lockstep.
module tb_cpu_sequencer;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   exp_retired;

    cpu_sequencer_if #(.CNT_W(16)) if0 ();
    cpu_sequencer_if #(.CNT_W(4))  if4 ();

    cpu_sequencer #(.TIMEOUT(15), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(if0.slave));
    cpu_sequencer #(.TIMEOUT(15), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    assign if4.run          = if0.run;
    assign if4.instr_class  = if0.instr_class;
    assign if4.branch_taken = if0.branch_taken;
    assign if4.mem_ready    = if0.mem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] C_ALU = 3'd0, C_LOAD = 3'd1, C_STORE = 3'd2, C_BRANCH = 3'd3;
    localparam logic [2:0] C_JUMP = 3'd4, C_HALT = 3'd5, C_NOP = 3'd6, C_ILL = 3'd7;

    // Strobe vector order: {pc_en, pc_ld, ir_ld, mem_rd, mem_wr, rf_we}
    function automatic logic [5:0] strobes();
        return {if0.pc_en, if0.pc_ld, if0.ir_ld, if0.mem_rd, if0.mem_wr, if0.rf_we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One FETCH/DECODE/EXEC instruction with mem_ready=1 and run=1.
    task automatic do_instr(input logic [2:0] cls, input logic taken, input logic [5:0] exp_exec);
        tick();
        if0.instr_class = cls; if0.branch_taken = taken; if0.run = 1'b1; if0.mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (strobes() !== 6'b001100 || if0.state !== 3'd0) begin
            tests_failed++;
            $display("FAIL fetch cls=%0d: strobes=%b state=%0d, expected strobes=001100 state=0", cls, strobes(), if0.state);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (strobes() !== 6'b000000 || if0.state !== 3'd1) begin
            tests_failed++;
            $display("FAIL decode cls=%0d: strobes=%b state=%0d, expected strobes=000000 state=1", cls, strobes(), if0.state);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (strobes() !== exp_exec || if0.state !== 3'd2) begin
            tests_failed++;
            $display("FAIL exec cls=%0d taken=%0d: strobes=%b state=%0d, expected strobes=%b state=2", cls, taken, strobes(), if0.state, exp_exec);
        end
        exp_retired++;
        $display("[TB] instr cls=%0d taken=%0d exec strobes=%b", cls, taken, strobes());
    endtask

    task automatic test_reset();
        rst = 1'b1; if0.run = 1'b1; if0.mem_ready = 1'b1; if0.instr_class = C_ALU; if0.branch_taken = 1'b0;
        tick(); tick();
        @(negedge clk);
        tests_run++;
        if (strobes() !== 6'b000000 || if0.halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: strobes=%b halted=%b, expected 000000 halted=0", strobes(), if0.halted);
        end
        tests_run++;
        if (if0.state !== 3'd0 || if0.fault !== 1'b0 || if0.retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d fault=%b retired=%0d, expected 0/0/0", if0.state, if0.fault, if0.retired);
        end
        tick();
        rst = 1'b0; if0.mem_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.mem_rd !== 1'b1 || if0.state !== 3'd0) begin
            tests_failed++;
            $display("FAIL first_fetch: mem_rd=%b state=%0d, expected mem_rd=1 state=0", if0.mem_rd, if0.state);
        end
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (strobes() !== 6'b000000 || if0.state !== 3'd0) begin
            tests_failed++;
            $display("FAIL run0_idle: strobes=%b state=%0d, expected 000000 state=0", strobes(), if0.state);
        end
        exp_retired = 0;
        $display("[TB] reset done");
    endtask

    task automatic test_alu();
        do_instr(C_ALU, 1'b0, 6'b100001);
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd0 || strobes() !== 6'b000000 || if0.retired !== 16'(exp_retired)) begin
            tests_failed++;
            $display("FAIL alu_end: state=%0d strobes=%b retired=%0d, expected 0/000000/%0d", if0.state, strobes(), if0.retired, exp_retired);
        end
    endtask

    task automatic test_load_wait();
        tick();
        if0.instr_class = C_LOAD; if0.run = 1'b1; if0.mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (strobes() !== 6'b001100) begin
            tests_failed++;
            $display("FAIL load_fetch: strobes=%b, expected 001100", strobes());
        end
        tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tick();
            if0.mem_ready = (i == 3);
            @(negedge clk);
            tests_run++;
            if (if0.state !== 3'd3 || strobes() !== 6'b000100) begin
                tests_failed++;
                $display("FAIL load_mem%0d: state=%0d strobes=%b, expected state=3 strobes=000100", i, if0.state, strobes());
            end
        end
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd4 || strobes() !== 6'b100001) begin
            tests_failed++;
            $display("FAIL load_wb: state=%0d strobes=%b, expected state=4 strobes=100001", if0.state, strobes());
        end
        exp_retired++;
        tick();
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd0 || if0.fault !== 1'b0 || if0.retired !== 16'(exp_retired)) begin
            tests_failed++;
            $display("FAIL load_end: state=%0d fault=%b retired=%0d, expected 0/0/%0d", if0.state, if0.fault, if0.retired, exp_retired);
        end
        $display("[TB] load with 3 wait cycles retired=%0d", if0.retired);
    endtask

    task automatic test_branch();
        do_instr(C_BRANCH, 1'b1, 6'b010000);
        do_instr(C_BRANCH, 1'b0, 6'b100000);
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.retired !== 16'(exp_retired)) begin
            tests_failed++;
            $display("FAIL branch_retired: retired=%0d, expected %0d", if0.retired, exp_retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] cls_tab [3]  = '{C_JUMP, C_NOP, C_ILL};
        logic [5:0] exp_tab [3]  = '{6'b010000, 6'b100000, 6'b100000};
        for (int i = 0; i < 3; i++) do_instr(cls_tab[i], 1'b0, exp_tab[i]);
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.retired !== 16'(exp_retired) || if0.fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_retired: retired=%0d fault=%b, expected %0d fault=0", if0.retired, if0.fault, exp_retired);
        end
    endtask

    task automatic test_store();
        tick();
        if0.instr_class = C_STORE; if0.run = 1'b1; if0.mem_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd3 || strobes() !== 6'b100010) begin
            tests_failed++;
            $display("FAIL store_mem: state=%0d strobes=%b, expected state=3 strobes=100010", if0.state, strobes());
        end
        exp_retired++;
        tick();
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd0 || if0.retired !== 16'(exp_retired)) begin
            tests_failed++;
            $display("FAIL store_end: state=%0d retired=%0d, expected 0/%0d", if0.state, if0.retired, exp_retired);
        end
        $display("[TB] store retired=%0d", if0.retired);
    endtask

    task automatic test_timeout();
        tick();
        if0.instr_class = C_NOP; if0.run = 1'b1; if0.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            logic [5:0] exp_s;
            @(negedge clk);
            exp_s = (i < 14) ? 6'b000100 : 6'b000000;
            tests_run++;
            if (strobes() !== exp_s || if0.state !== 3'd0) begin
                tests_failed++;
                $display("FAIL timeout_wait%0d: strobes=%b state=%0d, expected strobes=%b state=0", i, strobes(), if0.state, exp_s);
            end
            tick();
        end
        if0.mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd5 || if0.fault !== 1'b1 || if0.halted !== 1'b1 || strobes() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL timeout_halt: state=%0d fault=%b halted=%b strobes=%b, expected 5/1/1/000000", if0.state, if0.fault, if0.halted, strobes());
        end
        tick(); tick();
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd5 || strobes() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL halt_stays: state=%0d strobes=%b, expected 5/000000", if0.state, strobes());
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (if0.halted !== 1'b0 || strobes() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL halt_rst_out: halted=%b strobes=%b, expected 0/000000", if0.halted, strobes());
        end
        tick();
        rst = 1'b0; if0.run = 1'b0;
        @(negedge clk);
        exp_retired = 0;
        tests_run++;
        if (if0.state !== 3'd0 || if0.fault !== 1'b0 || if0.retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL timeout_recover: state=%0d fault=%b retired=%0d, expected 0/0/0", if0.state, if0.fault, if0.retired);
        end
        $display("[TB] timeout and recovery done");
    endtask

    task automatic test_halt_and_reset_mid_store();
        do_instr(C_ALU, 1'b0, 6'b100001);
        tick();
        if0.instr_class = C_HALT;
        @(negedge clk);
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd1) begin
            tests_failed++;
            $display("FAIL haltcls_decode: state=%0d, expected 1", if0.state);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd5 || if0.halted !== 1'b1 || if0.fault !== 1'b0 || if0.retired !== 16'(exp_retired)) begin
            tests_failed++;
            $display("FAIL haltcls: state=%0d halted=%b fault=%b retired=%0d, expected 5/1/0/%0d", if0.state, if0.halted, if0.fault, if0.retired, exp_retired);
        end
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        exp_retired = 0;
        tick();
        if0.instr_class = C_STORE; if0.run = 1'b1; if0.mem_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        if0.mem_ready = 1'b0; if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd3 || strobes() !== 6'b000010) begin
            tests_failed++;
            $display("FAIL store_wait: state=%0d strobes=%b, expected 3/000010", if0.state, strobes());
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (if0.mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_store_wr: mem_wr=%b, expected 0", if0.mem_wr);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if0.state !== 3'd0 || if0.mem_wr !== 1'b0 || if0.retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_store: state=%0d mem_wr=%b retired=%0d, expected 0/0/0", if0.state, if0.mem_wr, if0.retired);
        end
        $display("[TB] halt class and reset mid-store done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) do_instr(C_NOP, 1'b0, 6'b100000);
        tick();
        if0.run = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if4.retired !== 4'd0 || if0.retired !== 16'(exp_retired)) begin
            tests_failed++;
            $display("FAIL wrap: retired4=%0d retired16=%0d, expected 0 and %0d", if4.retired, if0.retired, exp_retired);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            tests_run++;
            if (if0.mem_rd !== 1'b0 || if0.state !== 3'd0) begin
                tests_failed++;
                $display("FAIL paused%0d: mem_rd=%b state=%0d, expected 0/0", i, if0.mem_rd, if0.state);
            end
        end
        $display("[TB] 16 NOPs, narrow counter=%0d", if4.retired);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        exp_retired = 0;
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_store();
        test_timeout();
        test_halt_and_reset_mid_store();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
